// File: rtl/dcm_multi.sv
// Multi-channel programmable clock divider. Each channel swaps divider codes
// only on a half-period boundary so that clk_out never glitches.
module dcm_multi #(
    parameter int NCH   = 4,
    parameter int CH_W  = 2,
    parameter int DIV_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               update,
    input  logic [CH_W-1:0]    ch_sel,
    input  logic [2:0]         prog_in,
    output logic [3*NCH-1:0]   prog_out,
    output logic [NCH-1:0]     pending,
    output logic               clk_1,
    output logic [NCH-1:0]     clk_out,
    output logic [NCH-1:0]     tick
);

    logic [NCH-1:0][2:0]       a_q, a_d, p_q, p_d;
    logic [NCH-1:0]            f_q, f_d, t_q, t_d;
    logic [NCH-1:0][DIV_W-1:0] c_q, c_d;
    logic [NCH-1:0][DIV_W-1:0] half;
    logic                      wr_en;

    function automatic logic [DIV_W-1:0] half_of(input logic [2:0] code);
        case (code)
            3'd1:    half_of = DIV_W'(1);
            3'd2:    half_of = DIV_W'(2);
            3'd3:    half_of = DIV_W'(5);
            3'd4:    half_of = DIV_W'(8);
            3'd5:    half_of = DIV_W'(16);
            3'd6:    half_of = DIV_W'(32);
            3'd7:    half_of = DIV_W'(64);
            default: half_of = DIV_W'(0);
        endcase
    endfunction

    assign wr_en = update && (int'(ch_sel) < NCH);

    always_comb begin
        half = '0;
        for (int i = 0; i < NCH; i++) begin
            half[i] = half_of(a_q[i]);
        end
    end

    always_comb begin
        a_d = a_q;
        p_d = p_q;
        f_d = f_q;
        c_d = c_q;
        t_d = t_q;
        for (int i = 0; i < NCH; i++) begin
            if (a_q[i] == 3'd0) begin
                c_d[i] = DIV_W'(1);
                t_d[i] = 1'b0;
                if (f_q[i]) begin
                    a_d[i] = p_q[i];
                    f_d[i] = 1'b0;
                end
            end else if (c_q[i] == half[i]) begin
                c_d[i] = DIV_W'(1);
                t_d[i] = ~t_q[i];
                // Entering bypass waits for the falling toggle so clk_out lands low.
                if (f_q[i] && ((p_q[i] != 3'd0) || t_q[i])) begin
                    a_d[i] = p_q[i];
                    f_d[i] = 1'b0;
                end
            end else begin
                c_d[i] = c_q[i] + DIV_W'(1);
            end
            // A write on an apply edge lands after the apply, so it stays pending.
            if (wr_en && (int'(ch_sel) == i)) begin
                p_d[i] = prog_in;
                f_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            p_q <= '0;
            f_q <= '0;
            t_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                c_q[i] <= DIV_W'(1);
            end
        end else begin
            a_q <= a_d;
            p_q <= p_d;
            f_q <= f_d;
            t_q <= t_d;
            c_q <= c_d;
        end
    end

    always_comb begin
        clk_out = '0;
        tick    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (a_q[i] == 3'd0) begin
                clk_out[i] = clk;
                tick[i]    = 1'b1;
            end else begin
                clk_out[i] = t_q[i];
                tick[i]    = (c_q[i] == half[i]);
            end
        end
    end

    assign prog_out = a_q;
    assign pending  = f_q;
    assign clk_1    = clk;

endmodule

// File: tb/tb_dcm_multi.sv
// Bench for dcm_multi: directed vector table, corner-case sequences and a
// randomized run against a per-channel behavioural model.
module tb_dcm_multi;

    localparam int NCH   = 4;
    localparam int CH_W  = 3;
    localparam int DIV_W = 9;

    logic              clk;
    logic              rst;
    logic              update;
    logic [CH_W-1:0]   ch_sel;
    logic [2:0]        prog_in;
    logic [3*NCH-1:0]  prog_out;
    logic [NCH-1:0]    pending;
    logic              clk_1;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    tick;

    dcm_multi #(.NCH(NCH), .CH_W(CH_W), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .update   (update),
        .ch_sel   (ch_sel),
        .prog_in  (prog_in),
        .prog_out (prog_out),
        .pending  (pending),
        .clk_1    (clk_1),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: each channel remembers its code, a queued code, the output level
    // and how many cycles of the current half-period have elapsed.
    int half_tab[8] = '{0, 1, 2, 5, 8, 16, 32, 64};
    int m_code[NCH];
    int m_pcode[NCH];
    bit m_pend[NCH];
    bit m_level[NCH];
    int m_elapsed[NCH];

    logic [3*NCH-1:0] s_prog;
    logic [NCH-1:0]   s_pend, s_clk, s_tick;
    logic             s_clk1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_code[i] = 0; m_pcode[i] = 0; m_pend[i] = 0;
            m_level[i] = 0; m_elapsed[i] = 0;
        end
    endtask

    task automatic model_step(input logic upd, input int sel, input int code);
        int h;
        for (int i = 0; i < NCH; i++) begin
            h = half_tab[m_code[i]];
            if (m_code[i] == 0) begin
                if (m_pend[i]) begin
                    m_code[i] = m_pcode[i]; m_pend[i] = 0;
                    m_level[i] = 0; m_elapsed[i] = 0;
                end
            end else if (m_elapsed[i] == h - 1) begin
                if (m_pend[i] && (m_pcode[i] != 0 || m_level[i])) begin
                    m_code[i] = m_pcode[i]; m_pend[i] = 0;
                end
                m_level[i] = !m_level[i];
                m_elapsed[i] = 0;
            end else begin
                m_elapsed[i]++;
            end
        end
        if (upd && sel < NCH) begin
            m_pcode[sel] = code;
            m_pend[sel] = 1;
        end
    endtask

    task automatic check_all();
        logic [3*NCH-1:0] ep;
        logic [NCH-1:0]   epd, eco, etk;
        for (int i = 0; i < NCH; i++) begin
            ep[3*i +: 3] = 3'(m_code[i]);
            epd[i] = m_pend[i];
            eco[i] = (m_code[i] == 0) ? clk : m_level[i];
            etk[i] = (m_code[i] == 0) || (m_elapsed[i] == half_tab[m_code[i]] - 1);
        end
        check("model prog_out", 32'(prog_out), 32'(ep));
        check("model pending", 32'(pending), 32'(epd));
        check("model clk_out", 32'(clk_out), 32'(eco));
        check("model tick", 32'(tick), 32'(etk));
        check("model clk_1", 32'(clk_1), 32'(clk));
    endtask

    // Drives now, checks after the next posedge and the following negedge.
    task automatic cycle(input logic upd, input int sel, input int code);
        update  = upd;
        ch_sel  = CH_W'(sel);
        prog_in = 3'(code);
        @(posedge clk);
        model_step(upd, sel, code);
        #1;
        s_prog = prog_out; s_pend = pending; s_clk = clk_out;
        s_tick = tick; s_clk1 = clk_1;
        check_all();
        @(negedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        update = 1'b0; ch_sel = '0; prog_in = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();
    endtask

    typedef struct {
        logic             upd;
        int               sel;
        int               code;
        logic [3*NCH-1:0] prog;
        logic [NCH-1:0]   pend;
        logic [NCH-1:0]   clko;
        logic [NCH-1:0]   tck;
    } vec_t;

    vec_t tab[12];

    int pend_cnt, gap, gaps_seen, falls;
    int gap_val[2];
    logic last_v;
    bit saw_high;

    initial begin
        // Outputs sampled just after posedge, so bypass channels read 1.
        tab[0]  = '{1'b1, 0, 1, 12'h000, 4'b0001, 4'b1111, 4'b1111};
        tab[1]  = '{1'b0, 0, 0, 12'h001, 4'b0000, 4'b1110, 4'b1111};
        tab[2]  = '{1'b0, 0, 0, 12'h001, 4'b0000, 4'b1111, 4'b1111};
        tab[3]  = '{1'b0, 0, 0, 12'h001, 4'b0000, 4'b1110, 4'b1111};
        tab[4]  = '{1'b1, 4, 5, 12'h001, 4'b0000, 4'b1111, 4'b1111};
        tab[5]  = '{1'b1, 7, 3, 12'h001, 4'b0000, 4'b1110, 4'b1111};
        tab[6]  = '{1'b1, 0, 0, 12'h001, 4'b0001, 4'b1111, 4'b1111};
        tab[7]  = '{1'b0, 0, 0, 12'h000, 4'b0000, 4'b1111, 4'b1111};
        tab[8]  = '{1'b1, 3, 2, 12'h000, 4'b1000, 4'b1111, 4'b1111};
        tab[9]  = '{1'b0, 0, 0, 12'h400, 4'b0000, 4'b0111, 4'b0111};
        tab[10] = '{1'b0, 0, 0, 12'h400, 4'b0000, 4'b0111, 4'b1111};
        tab[11] = '{1'b0, 0, 0, 12'h400, 4'b0000, 4'b1111, 4'b0111};

        do_reset();
        check("reset prog_out", 32'(prog_out), 32'h0);
        check("reset tick", 32'(tick), 32'hf);
        for (int v = 0; v < 12; v++) begin
            cycle(tab[v].upd, tab[v].sel, tab[v].code);
            check($sformatf("vec%0d prog_out", v), 32'(s_prog), 32'(tab[v].prog));
            check($sformatf("vec%0d pending", v), 32'(s_pend), 32'(tab[v].pend));
            check($sformatf("vec%0d clk_out", v), 32'(s_clk), 32'(tab[v].clko));
            check($sformatf("vec%0d tick", v), 32'(s_tick), 32'(tab[v].tck));
            check($sformatf("vec%0d clk_1", v), 32'(s_clk1), 32'h1);
        end

        // Ch2 code 3 reprogrammed to 5 two cycles into a half-period.
        do_reset();
        cycle(1, 2, 3); cycle(0, 0, 0); cycle(0, 0, 0);
        cycle(1, 2, 5);
        pend_cnt = s_pend[2] ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            cycle(0, 0, 0);
            if (s_pend[2]) pend_cnt++;
            else break;
        end
        check("ch2 pending cycles", 32'(pend_cnt), 32'd3);
        last_v = s_clk[2]; gap = 0; gaps_seen = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(0, 0, 0);
            gap++;
            if (s_clk[2] != last_v) begin
                if (gaps_seen < 2) gap_val[gaps_seen] = gap;
                gaps_seen++;
                last_v = s_clk[2];
                gap = 0;
            end
        end
        check("ch2 toggles seen", 32'(gaps_seen >= 2), 32'd1);
        check("ch2 half period a", 32'(gap_val[0]), 32'd16);
        check("ch2 half period b", 32'(gap_val[1]), 32'd16);
        check("ch2 prog_out", 32'(s_prog[8:6]), 32'd5);

        // Ch1 code 4 to bypass, requested while its output is low.
        do_reset();
        cycle(1, 1, 4); cycle(0, 0, 0);
        cycle(1, 1, 0);
        pend_cnt = s_pend[1] ? 1 : 0;
        saw_high = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(0, 0, 0);
            if (s_pend[1]) begin
                pend_cnt++;
                if (s_clk[1]) saw_high = 1;
            end else break;
        end
        check("ch1 bypass latency", 32'(pend_cnt), 32'd15);
        check("ch1 rising toggle kept", 32'(saw_high), 32'd1);
        check("ch1 prog_out", 32'(s_prog[5:3]), 32'd0);

        // Ch3 back-to-back updates: last write wins, one clear.
        do_reset();
        cycle(1, 3, 5); cycle(0, 0, 0);
        cycle(1, 3, 6); cycle(1, 3, 2);
        falls = 0; last_v = s_pend[3];
        for (int k = 0; k < 40; k++) begin
            cycle(0, 0, 0);
            if (last_v && !s_pend[3]) falls++;
            last_v = s_pend[3];
        end
        check("ch3 pending clears", 32'(falls), 32'd1);
        check("ch3 prog_out", 32'(s_prog[11:9]), 32'd2);

        // Out-of-range channel then asynchronous reset with a code pending.
        do_reset();
        cycle(1, 0, 6); cycle(0, 0, 0);
        cycle(1, 5, 3);
        check("bad ch pending", 32'(s_pend), 32'h0);
        cycle(1, 0, 2);
        #2;
        rst = 1'b1;
        #1;
        check("async rst prog_out", 32'(prog_out), 32'h0);
        check("async rst pending", 32'(pending), 32'h0);
        check("async rst tick", 32'(tick), 32'hf);
        check("async rst clk_out low", 32'(clk_out), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst clk_out high", 32'(clk_out), 32'hf);
        check("rst clk_1 high", 32'(clk_1), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 80; k++) cycle(0, 0, 0);
        check("no apply after rst", 32'(s_prog), 32'h0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0)
                cycle(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            else
                cycle(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
